// File: rtl/spi_cmd_decoder_if.sv
// Bundle of the SPI-device side and memory-read side signals of spi_cmd_decoder.
// The decoder connects through the slave modport; the driving side uses master.
interface spi_cmd_decoder_if #(
   parameter int ADDR_BITS = 24
);
   logic                 spi_cs;
   logic                 spi_rx_strobe;
   logic                 spi_rx_cmd;
   logic [7:0]           spi_rx_data;
   logic [7:0]           spi_tx_data;
   logic                 rd_req;
   logic [ADDR_BITS-1:0] rd_addr;
   logic                 rd_valid;
   logic [7:0]           rd_data;
   logic                 cmd_strobe;
   logic [7:0]           cmd_byte;
   logic                 tx_underrun;

   modport slave (
      input  spi_cs, spi_rx_strobe, spi_rx_cmd, spi_rx_data, rd_valid, rd_data,
      output spi_tx_data, rd_req, rd_addr, cmd_strobe, cmd_byte, tx_underrun
   );

   modport master (
      output spi_cs, spi_rx_strobe, spi_rx_cmd, spi_rx_data, rd_valid, rd_data,
      input  spi_tx_data, rd_req, rd_addr, cmd_strobe, cmd_byte, tx_underrun
   );
endinterface

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: system-clock side of the SPI flash emulation path.
// Synchronises the toggle strobes and chip select from spi_device, decodes
// READ (0x03), assembles the address, issues memory reads and returns
// prefetched bytes on spi_tx_data.
// Optional feature macro: SPI_FAST_READ_EN (accepts FAST READ 0x0B with one
// dummy byte between address and data).
module spi_cmd_decoder #(
   parameter int ADDR_BITS   = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   spi_cmd_decoder_if.slave  bus
);
   localparam int ADDR_BYTES = ADDR_BITS / 8;
   localparam int CNT_W      = $clog2(ADDR_BYTES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ADDR_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DATA   = 3'd2,
      ST_IGNORE = 3'd3
`ifdef SPI_FAST_READ_EN
      ,
      ST_DUMMY  = 3'd4
`endif
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers: bit 0 rx_strobe, bit 1 rx_cmd, bit 2 cs
   // ------------------------------------------------------------------
   logic [2:0] async_in;
   logic [2:0] sync_out;
   logic [1:0] hist_reg;

   assign async_in = {bus.spi_cs, bus.spi_rx_cmd, bus.spi_rx_strobe};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_reg;

         // Shift chain; on reset every stage takes the live input so no edge is seen afterwards
         always_ff @(posedge clk) begin
            if (reset)
               chain_reg <= {SYNC_STAGES{async_in[gi]}};
            else
               chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
         end

         assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
      end
   endgenerate

   // Toggle history for the two strobes; an edge is a difference from the synchronised value
   always_ff @(posedge clk) begin
      if (reset)
         hist_reg <= async_in[1:0];
      else
         hist_reg <= sync_out[1:0];
   end

   logic strobe_ev;
   logic cmd_ev;
   logic cs_high;
   logic cmd_byte_ev;
   logic payload_ev;
   logic [7:0] rx_byte;

   assign strobe_ev   = sync_out[0] ^ hist_reg[0];
   assign cmd_ev      = sync_out[1] ^ hist_reg[1];
   assign cs_high     = sync_out[2];
   assign cmd_byte_ev = strobe_ev & cmd_ev;
   assign payload_ev  = strobe_ev & ~cmd_ev;
   assign rx_byte     = bus.spi_rx_data;

   // ------------------------------------------------------------------
   // Decoder state
   // ------------------------------------------------------------------
   state_t                state_reg,      state_next;
   logic [CNT_W-1:0]      cnt_reg,        cnt_next;
   logic [ADDR_BITS-1:0]  addr_sr_reg,    addr_sr_next;
   logic [ADDR_BITS-1:0]  rd_addr_reg,    rd_addr_next;
   logic [ADDR_BITS-1:0]  fetch_addr_reg, fetch_addr_next;
   logic                  rd_req_reg,     rd_req_next;
   logic                  pending_reg,    pending_next;
   logic                  req_wait_reg,   req_wait_next;
   logic                  have_reg,       have_next;
   logic                  first_reg,      first_next;
   logic [7:0]            hold_reg,       hold_next;
   logic [7:0]            tx_data_reg,    tx_data_next;
   logic [7:0]            cmd_byte_reg,   cmd_byte_next;
   logic                  cmd_strobe_reg, cmd_strobe_next;
   logic                  underrun_reg,   underrun_next;
   logic                  is_read;
   logic [ADDR_BITS-1:0]  addr_shifted;

   // State register and all datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         addr_sr_reg    <= '0;
         rd_addr_reg    <= '0;
         fetch_addr_reg <= '0;
         rd_req_reg     <= 1'b0;
         pending_reg    <= 1'b0;
         req_wait_reg   <= 1'b0;
         have_reg       <= 1'b0;
         first_reg      <= 1'b0;
         hold_reg       <= '0;
         tx_data_reg    <= '0;
         cmd_byte_reg   <= '0;
         cmd_strobe_reg <= 1'b0;
         underrun_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         addr_sr_reg    <= addr_sr_next;
         rd_addr_reg    <= rd_addr_next;
         fetch_addr_reg <= fetch_addr_next;
         rd_req_reg     <= rd_req_next;
         pending_reg    <= pending_next;
         req_wait_reg   <= req_wait_next;
         have_reg       <= have_next;
         first_reg      <= first_next;
         hold_reg       <= hold_next;
         tx_data_reg    <= tx_data_next;
         cmd_byte_reg   <= cmd_byte_next;
         cmd_strobe_reg <= cmd_strobe_next;
         underrun_reg   <= underrun_next;
      end
   end

   // Next-state logic: deselect, read response, byte decode, then deferred read issue
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      addr_sr_next    = addr_sr_reg;
      rd_addr_next    = rd_addr_reg;
      fetch_addr_next = fetch_addr_reg;
      rd_req_next     = 1'b0;
      pending_next    = pending_reg;
      req_wait_next   = req_wait_reg;
      have_next       = have_reg;
      first_next      = first_reg;
      hold_next       = hold_reg;
      tx_data_next    = tx_data_reg;
      cmd_byte_next   = cmd_byte_reg;
      cmd_strobe_next = 1'b0;
      underrun_next   = underrun_reg;
      addr_shifted    = ADDR_BITS'({addr_sr_reg, rx_byte});
      is_read         = (rx_byte == 8'h03);
`ifdef SPI_FAST_READ_EN
      if (rx_byte == 8'h0B)
         is_read = 1'b1;
`endif

      if (cs_high) begin
         // Deselect abandons the transaction; any response still in flight is dropped
         state_next    = ST_IDLE;
         cnt_next      = '0;
         pending_next  = 1'b0;
         req_wait_next = 1'b0;
         have_next     = 1'b0;
         first_next    = 1'b0;
      end else begin
         // Memory response: always lands in hold; the very first byte also goes straight out
         if (bus.rd_valid && pending_reg) begin
            pending_next = 1'b0;
            hold_next    = bus.rd_data;
            have_next    = 1'b1;
            if (first_reg) begin
               tx_data_next = bus.rd_data;
               first_next   = 1'b0;
            end
         end

         if (cmd_byte_ev) begin
            // A command byte restarts decoding from scratch in any state
            cmd_byte_next   = rx_byte;
            cmd_strobe_next = 1'b1;
            cnt_next        = '0;
            pending_next    = 1'b0;
            req_wait_next   = 1'b0;
            have_next       = 1'b0;
            first_next      = 1'b0;
            state_next      = is_read ? ST_ADDR : ST_IGNORE;
         end else if (payload_ev) begin
            case (state_reg)
               ST_ADDR: begin
                  addr_sr_next = addr_shifted;
                  cnt_next     = cnt_reg + CNT_W'(1);
                  if (cnt_reg == LAST_CNT) begin
                     rd_addr_next    = addr_shifted;
                     fetch_addr_next = addr_shifted + ADDR_BITS'(1);
                     rd_req_next     = 1'b1;
                     pending_next    = 1'b1;
                     first_next      = 1'b1;
                     have_next       = 1'b0;
`ifdef SPI_FAST_READ_EN
                     state_next = (cmd_byte_reg == 8'h0B) ? ST_DUMMY : ST_DATA;
`else
                     state_next = ST_DATA;
`endif
                  end
               end
`ifdef SPI_FAST_READ_EN
               ST_DUMMY: begin
                  // Dummy byte is consumed while the first read is in flight
                  state_next = ST_DATA;
               end
`endif
               ST_DATA: begin
                  if (have_next) begin
                     tx_data_next = hold_next;
                     have_next    = 1'b0;
                  end else begin
                     underrun_next = 1'b1;
                  end
                  if (!pending_next && !req_wait_reg) begin
                     rd_addr_next    = fetch_addr_next;
                     fetch_addr_next = fetch_addr_next + ADDR_BITS'(1);
                     rd_req_next     = 1'b1;
                     pending_next    = 1'b1;
                  end else begin
                     // A read is still outstanding; if one is already queued, skip past its byte
                     if (req_wait_reg)
                        fetch_addr_next = fetch_addr_next + ADDR_BITS'(1);
                     req_wait_next = 1'b1;
                  end
               end
               default: ;
            endcase
         end

         // A queued request goes out as soon as the outstanding read has completed
         if (req_wait_next && !pending_next) begin
            rd_addr_next    = fetch_addr_next;
            fetch_addr_next = fetch_addr_next + ADDR_BITS'(1);
            rd_req_next     = 1'b1;
            pending_next    = 1'b1;
            req_wait_next   = 1'b0;
         end
      end
   end

   assign bus.spi_tx_data = tx_data_reg;
   assign bus.rd_req      = rd_req_reg;
   assign bus.rd_addr     = rd_addr_reg;
   assign bus.cmd_strobe  = cmd_strobe_reg;
   assign bus.cmd_byte    = cmd_byte_reg;
   assign bus.tx_underrun = underrun_reg;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: drives toggle-strobe bytes, models a
// memory answering reads with mem_byte(addr), and checks outputs.
module tb_spi_cmd_decoder;
   logic clk;
   logic reset;
   int   errors;
   int   checks;
   int   req_cnt;
   int   cmd_cnt;
   int   dbl_cnt;
   logic prev_req;
   logic prev_cmd;
   logic mem_en;
   logic [23:0] last_req_addr;

   spi_cmd_decoder_if #(.ADDR_BITS(24)) bus ();

   spi_cmd_decoder #(.ADDR_BITS(24), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      return a[23:16] ^ a[15:8] ^ a[7:0] ^ 8'hD5;
   endfunction

   // Memory model: answers each request two negedges after seeing it
   initial begin
      logic [23:0] a;
      bus.rd_valid = 1'b0;
      bus.rd_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.rd_req && mem_en) begin
            a = bus.rd_addr;
            repeat (2) @(negedge clk);
            bus.rd_data  = mem_byte(a);
            bus.rd_valid = 1'b1;
            @(negedge clk);
            bus.rd_valid = 1'b0;
         end
      end
   end

   // Pulse monitor
   initial begin
      req_cnt = 0; cmd_cnt = 0; dbl_cnt = 0; prev_req = 1'b0; prev_cmd = 1'b0;
      last_req_addr = '0;
   end
   always @(negedge clk) begin
      if (bus.rd_req) begin
         req_cnt++;
         last_req_addr = bus.rd_addr;
      end
      if (bus.cmd_strobe) cmd_cnt++;
      if ((bus.rd_req && prev_req) || (bus.cmd_strobe && prev_cmd)) dbl_cnt++;
      prev_req = bus.rd_req;
      prev_cmd = bus.cmd_strobe;
   end

   task automatic send_byte(input logic [7:0] b, input logic is_cmd);
      @(negedge clk);
      bus.spi_rx_data   = b;
      bus.spi_rx_strobe = ~bus.spi_rx_strobe;
      if (is_cmd) bus.spi_rx_cmd = ~bus.spi_rx_cmd;
      repeat (8) @(negedge clk);
      $display("byte %02h cmd=%0d req_cnt=%0d rd_addr=%06h tx=%02h", b, is_cmd, req_cnt, bus.rd_addr, bus.spi_tx_data);
   endtask

   task automatic cs_cycle();
      @(negedge clk);
      bus.spi_cs = 1'b1;
      repeat (6) @(negedge clk);
      bus.spi_cs = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (bus.spi_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got %h expected 00", bus.spi_tx_data); end
      checks++; if (bus.rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b expected 0", bus.rd_req); end
      checks++; if (bus.rd_addr !== 24'h0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 000000", bus.rd_addr); end
      checks++; if (bus.cmd_strobe !== 1'b0) begin errors++; $display("FAIL reset_cmd_strobe: got %b expected 0", bus.cmd_strobe); end
      checks++; if (bus.cmd_byte !== 8'h00) begin errors++; $display("FAIL reset_cmd_byte: got %h expected 00", bus.cmd_byte); end
      checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", bus.tx_underrun); end
   endtask

   task automatic test_read_basic();
      int c0, r0;
      cs_cycle();
      c0 = cmd_cnt; r0 = req_cnt;
      send_byte(8'h03, 1'b1);
      checks++; if (cmd_cnt - c0 !== 1) begin errors++; $display("FAIL rd_cmd_strobe_count: got %0d expected 1", cmd_cnt - c0); end
      checks++; if (bus.cmd_byte !== 8'h03) begin errors++; $display("FAIL rd_cmd_byte: got %h expected 03", bus.cmd_byte); end
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      checks++; if (req_cnt - r0 !== 1 || last_req_addr !== 24'h123456) begin errors++; $display("FAIL rd_first_req: got n=%0d addr=%h expected n=1 addr=123456", req_cnt - r0, last_req_addr); end
      checks++; if (bus.spi_tx_data !== 8'hA5) begin errors++; $display("FAIL rd_first_tx: got %h expected A5", bus.spi_tx_data); end
      send_byte(8'h00, 1'b0);
      checks++; if (req_cnt - r0 !== 2 || last_req_addr !== 24'h123457) begin errors++; $display("FAIL rd_next_req: got n=%0d addr=%h expected n=2 addr=123457", req_cnt - r0, last_req_addr); end
      checks++; if (bus.spi_tx_data !== 8'hA5) begin errors++; $display("FAIL rd_tx_held: got %h expected A5", bus.spi_tx_data); end
      send_byte(8'h00, 1'b0);
      checks++; if (bus.spi_tx_data !== 8'hA4) begin errors++; $display("FAIL rd_tx_second: got %h expected A4", bus.spi_tx_data); end
      checks++; if (last_req_addr !== 24'h123458) begin errors++; $display("FAIL rd_third_req: got %h expected 123458", last_req_addr); end
      checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL rd_no_underrun: got %b expected 0", bus.tx_underrun); end
   endtask

   task automatic test_wrap();
      cs_cycle();
      send_byte(8'h03, 1'b1);
      send_byte(8'hFF, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_byte(8'hFF, 1'b0);
      checks++; if (last_req_addr !== 24'hFFFFFF) begin errors++; $display("FAIL wrap_first_addr: got %h expected FFFFFF", last_req_addr); end
      checks++; if (bus.spi_tx_data !== 8'h2A) begin errors++; $display("FAIL wrap_first_tx: got %h expected 2A", bus.spi_tx_data); end
      send_byte(8'h00, 1'b0);
      checks++; if (last_req_addr !== 24'h000000) begin errors++; $display("FAIL wrap_second_addr: got %h expected 000000", last_req_addr); end
      send_byte(8'h00, 1'b0);
      checks++; if (bus.spi_tx_data !== 8'hD5) begin errors++; $display("FAIL wrap_second_tx: got %h expected D5", bus.spi_tx_data); end
   endtask

   task automatic test_unknown_cmd();
      int c0, r0;
      cs_cycle();
      c0 = cmd_cnt; r0 = req_cnt;
      send_byte(8'h9F, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'h12 + 8'(i), 1'b0);
      checks++; if (cmd_cnt - c0 !== 1) begin errors++; $display("FAIL unk_cmd_strobe_count: got %0d expected 1", cmd_cnt - c0); end
      checks++; if (bus.cmd_byte !== 8'h9F) begin errors++; $display("FAIL unk_cmd_byte: got %h expected 9F", bus.cmd_byte); end
      checks++; if (req_cnt - r0 !== 0) begin errors++; $display("FAIL unk_no_req: got %0d expected 0", req_cnt - r0); end
   endtask

   task automatic test_cs_abort();
      int r0;
      cs_cycle();
      r0 = req_cnt;
      send_byte(8'h03, 1'b1);
      send_byte(8'hAB, 1'b0);
      send_byte(8'hCD, 1'b0);
      cs_cycle();
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      checks++; if (req_cnt - r0 !== 0) begin errors++; $display("FAIL abort_no_early_req: got %0d expected 0", req_cnt - r0); end
      send_byte(8'h10, 1'b0);
      checks++; if (req_cnt - r0 !== 1 || last_req_addr !== 24'h000010) begin errors++; $display("FAIL abort_new_addr: got n=%0d addr=%h expected n=1 addr=000010", req_cnt - r0, last_req_addr); end
      checks++; if (bus.spi_tx_data !== 8'hC5) begin errors++; $display("FAIL abort_tx: got %h expected C5", bus.spi_tx_data); end
   endtask

   task automatic test_underrun();
      int r0;
      cs_cycle();
      mem_en = 1'b0;
      r0 = req_cnt;
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h20, 1'b0);
      checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL under_before: got %b expected 0", bus.tx_underrun); end
      send_byte(8'h00, 1'b0);
      checks++; if (bus.tx_underrun !== 1'b1) begin errors++; $display("FAIL under_set: got %b expected 1", bus.tx_underrun); end
      checks++; if (req_cnt - r0 !== 1) begin errors++; $display("FAIL under_one_outstanding: got %0d expected 1", req_cnt - r0); end
      mem_en = 1'b1;
      cs_cycle();
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h30, 1'b0);
      send_byte(8'h00, 1'b0);
      checks++; if (bus.tx_underrun !== 1'b1) begin errors++; $display("FAIL under_sticky: got %b expected 1", bus.tx_underrun); end
   endtask

   task automatic test_fast_read();
      int r0;
      cs_cycle();
      r0 = req_cnt;
      send_byte(8'h0B, 1'b1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      checks++; if (bus.cmd_byte !== 8'h0B) begin errors++; $display("FAIL fast_cmd_byte: got %h expected 0B", bus.cmd_byte); end
`ifdef SPI_FAST_READ_EN
      checks++; if (req_cnt - r0 !== 1 || last_req_addr !== 24'h000100) begin errors++; $display("FAIL fast_req: got n=%0d addr=%h expected n=1 addr=000100", req_cnt - r0, last_req_addr); end
      send_byte(8'h00, 1'b0);
      checks++; if (req_cnt - r0 !== 1) begin errors++; $display("FAIL fast_dummy_no_req: got %0d expected 1", req_cnt - r0); end
      checks++; if (bus.spi_tx_data !== 8'hD4) begin errors++; $display("FAIL fast_tx: got %h expected D4", bus.spi_tx_data); end
      send_byte(8'h00, 1'b0);
      checks++; if (last_req_addr !== 24'h000101) begin errors++; $display("FAIL fast_next_req: got %h expected 000101", last_req_addr); end
`else
      send_byte(8'h00, 1'b0);
      checks++; if (req_cnt - r0 !== 0) begin errors++; $display("FAIL fast_disabled_no_req: got %0d expected 0", req_cnt - r0); end
`endif
   endtask

   task automatic test_reset_mid_data();
      cs_cycle();
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      checks++; if (bus.spi_tx_data !== 8'hD7) begin errors++; $display("FAIL mid_tx_before: got %h expected D7", bus.spi_tx_data); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.spi_tx_data !== 8'h00 || bus.rd_addr !== 24'h0 || bus.cmd_byte !== 8'h00 ||
                    bus.tx_underrun !== 1'b0 || bus.rd_req !== 1'b0 || bus.cmd_strobe !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got tx=%h addr=%h cmd=%h und=%b req=%b cs=%b expected all 0",
                  bus.spi_tx_data, bus.rd_addr, bus.cmd_byte, bus.tx_underrun, bus.rd_req, bus.cmd_strobe);
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      checks++; if (dbl_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d double pulses expected 0", dbl_cnt); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      mem_en = 1'b1;
      reset  = 1'b1;
      bus.spi_cs        = 1'b1;
      bus.spi_rx_strobe = 1'b0;
      bus.spi_rx_cmd    = 1'b0;
      bus.spi_rx_data   = 8'h00;
      test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      test_read_basic();
      test_wrap();
      test_unknown_cmd();
      test_cs_abort();
      test_underrun();
      test_fast_read();
      test_reset_mid_data();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
